// File: rtl/maze_pkg.sv
// Shared constants, types and helpers for the DFS maze carver.
package maze_pkg;

  // Direction encoding; the scan order used by the picker is E,S,W,N with wrap
  localparam logic [1:0] DIR_E = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_W = 2'd2;
  localparam logic [1:0] DIR_N = 2'd3;

  // LFSR reset value / zero-seed substitute and Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  // Bit positions inside rd_walls = {south, east}
  localparam int WALL_E_BIT = 0;
  localparam int WALL_S_BIT = 1;
  localparam logic [1:0] WALLS_ALL = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_CARVE, ST_DONE} state_e;

  // Row-major cell index
  function automatic int cell_idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// Galois LFSR used as the carver's direction picker; a zero seed is replaced
// by the default so the register can never lock up.
module maze_lfsr
  import maze_pkg::*;
#(
  parameter int SEED_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [SEED_W-1:0] seed,
  output logic [SEED_W-1:0] value
);

  logic [SEED_W-1:0] lfsr_q, lfsr_d;

  // Next value: load wins over advance
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)
      lfsr_d = (seed == '0) ? SEED_W'(LFSR_DEFAULT) : seed;
    else if (advance)
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? SEED_W'(LFSR_TAPS) : '0);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED_W'(LFSR_DEFAULT);
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/maze_dfs_carver.sv
// Depth-first maze carver: explicit cell stack, one push/pop per cycle,
// wall bitmaps exposed through a combinational read port.
module maze_dfs_carver
  import maze_pkg::*;
#(
  parameter int MAZE_W = 16,
  parameter int MAZE_H = 8,
  parameter int SEED_W = 16,
  parameter int XW     = (MAZE_W > 1) ? $clog2(MAZE_W) : 1,
  parameter int YW     = (MAZE_H > 1) ? $clog2(MAZE_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEED_W-1:0] seed,
  input  logic [XW-1:0]     start_x,
  input  logic [YW-1:0]     start_y,
  output logic              busy,
  output logic              done,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  output logic [1:0]        rd_walls
);

  localparam int N   = MAZE_W * MAZE_H;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int SPW = $clog2(N) + 1;
  localparam int SD  = (N > 1) ? N - 1 : 1;

  state_e              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [N-1:0]        visited_q, visited_d;
  logic [N-1:0]        wall_e_q, wall_e_d;
  logic [N-1:0]        wall_s_q, wall_s_d;
  logic [SD-1:0][IW-1:0] stack_q, stack_d;
  logic [SPW-1:0]      sp_q, sp_d;
  logic [IW-1:0]       cur_q, cur_d, org_q, org_d;

  logic                lfsr_load, lfsr_adv;
  logic [SEED_W-1:0]   lfsr_val;
  logic                unused_lfsr_bits;

  maze_lfsr #(.SEED_W(SEED_W)) u_lfsr (
    .clk(clk), .rst(rst), .load(lfsr_load), .advance(lfsr_adv),
    .seed(seed), .value(lfsr_val)
  );

  // Only the two low bits steer the direction scan
  assign unused_lfsr_bits = ^lfsr_val[SEED_W-1:2];

  // Next-state, neighbour scan and stack/grid updates
  always_comb begin
    int ci, cx, cy, nb, sx, sy;
    logic [3:0] mask;
    logic [1:0] dir, d2;
    logic found;

    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    visited_d = visited_q;
    wall_e_d  = wall_e_q;
    wall_s_d  = wall_s_q;
    stack_d   = stack_q;
    sp_d      = sp_q;
    cur_d     = cur_q;
    org_d     = org_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    ci = int'(cur_q);
    cx = ci % MAZE_W;
    cy = ci / MAZE_W;
    sx = (int'(start_x) >= MAZE_W) ? 0 : int'(start_x);
    sy = (int'(start_y) >= MAZE_H) ? 0 : int'(start_y);

    // In-bounds unvisited neighbours, {N,W,S,E}
    mask = '0;
    if (cx + 1 < MAZE_W) mask[DIR_E] = !visited_q[ci + 1];
    if (cy + 1 < MAZE_H) mask[DIR_S] = !visited_q[ci + MAZE_W];
    if (cx > 0)          mask[DIR_W] = !visited_q[ci - 1];
    if (cy > 0)          mask[DIR_N] = !visited_q[ci - MAZE_W];

    // First set bit scanning upward from the LFSR pick, with wrap
    dir   = DIR_E;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d2 = lfsr_val[1:0] + 2'(k);
      if (!found && mask[d2]) begin
        dir   = d2;
        found = 1'b1;
      end
    end
    case (dir)
      DIR_E:   nb = ci + 1;
      DIR_S:   nb = ci + MAZE_W;
      DIR_W:   nb = ci - 1;
      default: nb = ci - MAZE_W;
    endcase

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
        if (start && !busy_q) begin
          org_d     = IW'(cell_idx(sx, sy, MAZE_W));
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          state_d   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        wall_e_d  = '1;
        wall_s_d  = '1;
        visited_d = '0;
        visited_d[int'(org_q)] = 1'b1;
        sp_d      = '0;
        cur_d     = org_q;
        state_d   = ST_CARVE;
      end
      ST_CARVE: begin
        lfsr_adv = 1'b1;
        if (mask != 4'd0) begin
          stack_d[int'(sp_q)] = cur_q;
          sp_d = sp_q + 1'b1;
          case (dir)
            DIR_E:   wall_e_d[ci] = 1'b0;
            DIR_W:   wall_e_d[nb] = 1'b0;
            DIR_S:   wall_s_d[ci] = 1'b0;
            default: wall_s_d[nb] = 1'b0;
          endcase
          visited_d[nb] = 1'b1;
          cur_d = IW'(nb);
        end else if (sp_q != '0) begin
          sp_d  = sp_q - 1'b1;
          cur_d = stack_q[int'(sp_q) - 1];
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset restores an all-walls, unvisited grid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      visited_q <= '0;
      wall_e_q  <= '1;
      wall_s_q  <= '1;
      stack_q   <= '0;
      sp_q      <= '0;
      cur_q     <= '0;
      org_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      visited_q <= visited_d;
      wall_e_q  <= wall_e_d;
      wall_s_q  <= wall_s_d;
      stack_q   <= stack_d;
      sp_q      <= sp_d;
      cur_q     <= cur_d;
      org_q     <= org_d;
    end
  end

  // Read port; anything off the grid reads as solid walls
  always_comb begin
    int ri;
    ri       = cell_idx(int'(rd_x), int'(rd_y), MAZE_W);
    rd_walls = WALLS_ALL;
    if (int'(rd_x) < MAZE_W && int'(rd_y) < MAZE_H) begin
      rd_walls[WALL_E_BIT] = wall_e_q[ri];
      rd_walls[WALL_S_BIT] = wall_s_q[ri];
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_maze_dfs_carver.sv
// Bench for maze_dfs_carver: 1x1, 4x4 and 16x8 instances, latency and
// spanning-tree property checks through the read port.
module tb_maze_dfs_carver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] seed = 16'h0;

  logic       st1 = 0, busy1, done1;
  logic [0:0] sx1 = 0, sy1 = 0, rx1 = 0, ry1 = 0;
  logic [1:0] rw1;
  logic       st4 = 0, busy4, done4;
  logic [1:0] sx4 = 0, sy4 = 0, rx4 = 0, ry4 = 0;
  logic [1:0] rw4;
  logic       st16 = 0, busy16, done16;
  logic [3:0] sx16 = 0, rx16 = 0;
  logic [2:0] sy16 = 0, ry16 = 0;
  logic [1:0] rw16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maze_dfs_carver #(.MAZE_W(1), .MAZE_H(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .seed(seed), .start_x(sx1), .start_y(sy1),
    .busy(busy1), .done(done1), .rd_x(rx1), .rd_y(ry1), .rd_walls(rw1));
  maze_dfs_carver #(.MAZE_W(4), .MAZE_H(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .seed(seed), .start_x(sx4), .start_y(sy4),
    .busy(busy4), .done(done4), .rd_x(rx4), .rd_y(ry4), .rd_walls(rw4));
  maze_dfs_carver u16 (
    .clk(clk), .rst(rst), .start(st16), .seed(seed), .start_x(sx16), .start_y(sy16),
    .busy(busy16), .done(done16), .rd_x(rx16), .rd_y(ry16), .rd_walls(rw16));

  logic [1:0] dmp [128];
  logic [1:0] dumps4 [6][16];
  logic [1:0] dump16 [128];

  typedef struct {
    logic [15:0] sd;
    int sx, sy, poke, same_as;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic done_of(input int w);
    return (w == 0) ? done1 : (w == 1) ? done4 : done16;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 0) ? busy1 : (w == 1) ? busy4 : busy16;
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      0: st1 = v;
      1: st4 = v;
      default: st16 = v;
    endcase
  endtask

  task automatic rd(input int w, input int x, input int y, output logic [1:0] r);
    case (w)
      0: begin rx1 = 1'(x); ry1 = 1'(y); #1 r = rw1; end
      1: begin rx4 = 2'(x); ry4 = 2'(y); #1 r = rw4; end
      default: begin rx16 = 4'(x); ry16 = 3'(y); #1 r = rw16; end
    endcase
  endtask

  // Start a run, check the accept cycle, then count edges until done rises.
  task automatic run(input int w, input logic [15:0] sd, input int x, input int y,
                     input int poke, output int edges);
    @(negedge clk);
    seed = sd;
    case (w)
      0: begin sx1 = 1'(x); sy1 = 1'(y); end
      1: begin sx4 = 2'(x); sy4 = 2'(y); end
      default: begin sx16 = 4'(x); sy16 = 3'(y); end
    endcase
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    chk("busy_after_start", int'(busy_of(w)), 1);
    chk("done_after_start", int'(done_of(w)), 0);
    edges = 0;
    while (!done_of(w) && edges < 2000) begin
      if (edges == poke) begin set_start(w, 1'b1); seed = 16'h5555; end
      @(posedge clk); #1;
      edges++;
      set_start(w, 1'b0);
    end
  endtask

  // Dump walls into dmp, count open walls, boundary breaches and BFS reach.
  task automatic analyze(input int w, input int W, input int H,
                         output int open, output int reached, output int bnd);
    int q[$];
    bit seen [128];
    int c, x, y;
    open = 0; bnd = 0; reached = 0;
    for (int i = 0; i < W * H; i++) begin
      rd(w, i % W, i / W, dmp[i]);
      if (!dmp[i][0]) open++;
      if (!dmp[i][1]) open++;
      if ((i % W == W - 1 && !dmp[i][0]) || (i / W == H - 1 && !dmp[i][1])) bnd++;
      seen[i] = 0;
    end
    seen[0] = 1;
    q.push_back(0);
    while (q.size() > 0) begin
      c = q.pop_front();
      reached++;
      x = c % W; y = c / W;
      if (x < W - 1 && !dmp[c][0] && !seen[c + 1]) begin seen[c + 1] = 1; q.push_back(c + 1); end
      if (x > 0 && !dmp[c - 1][0] && !seen[c - 1]) begin seen[c - 1] = 1; q.push_back(c - 1); end
      if (y < H - 1 && !dmp[c][1] && !seen[c + W]) begin seen[c + W] = 1; q.push_back(c + W); end
      if (y > 0 && !dmp[c - W][1] && !seen[c - W]) begin seen[c - W] = 1; q.push_back(c - W); end
    end
  endtask

  initial begin
    int e, op, rc, bd, diff;
    logic [1:0] r;

    vecs[0] = '{16'h1234, 0, 0, -1, -1};
    vecs[1] = '{16'h1234, 0, 0, -1, 0};
    vecs[2] = '{16'h0000, 1, 2, -1, -1};
    vecs[3] = '{16'hACE1, 1, 2, -1, 2};
    vecs[4] = '{16'h1234, 0, 0, 10, 0};
    vecs[5] = '{16'hBEEF, 3, 3, -1, -1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_done4", int'(done4), 0);
    chk("rst_busy16", int'(busy16), 0);
    chk("rst_done1", int'(done1), 0);
    diff = 0;
    for (int i = 0; i < 16; i++) begin rd(1, i % 4, i / 4, r); if (r != 2'b11) diff++; end
    chk("rst_walls4", diff, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cell grid
    run(0, 16'h1234, 0, 0, -1, e);
    chk("lat_1x1", e, 3);
    rd(0, 0, 0, r);
    chk("walls_1x1", int'(r), 3);
    rd(0, 1, 0, r);
    chk("oob_1x1", int'(r), 3);

    // 4x4 table: latency, tree property, reproducibility, ignored restart
    for (int v = 0; v < 6; v++) begin
      run(1, vecs[v].sd, vecs[v].sx, vecs[v].sy, vecs[v].poke, e);
      chk($sformatf("lat4_v%0d", v), e, 33);
      chk($sformatf("busy4_done_v%0d", v), int'(busy4), 0);
      analyze(1, 4, 4, op, rc, bd);
      chk($sformatf("open4_v%0d", v), op, 15);
      chk($sformatf("reach4_v%0d", v), rc, 16);
      chk($sformatf("bnd4_v%0d", v), bd, 0);
      for (int i = 0; i < 16; i++) dumps4[v][i] = dmp[i];
      if (vecs[v].same_as >= 0) begin
        diff = 0;
        for (int i = 0; i < 16; i++) if (dumps4[v][i] != dumps4[vecs[v].same_as][i]) diff++;
        chk($sformatf("same4_v%0d", v), diff, 0);
      end
    end

    // 16x8 default grid
    run(2, 16'h1234, 0, 3, -1, e);
    chk("lat16", e, 257);
    analyze(2, 16, 8, op, rc, bd);
    chk("open16", op, 127);
    chk("reach16", rc, 128);
    chk("bnd16", bd, 0);
    for (int i = 0; i < 128; i++) dump16[i] = dmp[i];
    run(2, 16'h1234, 0, 3, -1, e);
    analyze(2, 16, 8, op, rc, bd);
    diff = 0;
    for (int i = 0; i < 128; i++) if (dmp[i] != dump16[i]) diff++;
    chk("same16", diff, 0);

    // start in the first done=1 cycle is accepted; done drops then returns
    run(1, 16'h0BAD, 2, 1, -1, e);
    set_start(1, 1'b1);
    @(posedge clk); #1;
    set_start(1, 1'b0);
    chk("b2b_done_drop", int'(done4), 0);
    chk("b2b_busy", int'(busy4), 1);
    e = 0;
    while (!done4 && e < 2000) begin @(posedge clk); #1; e++; end
    chk("b2b_lat", e, 33);

    // Asynchronous reset mid-carve
    @(negedge clk);
    seed = 16'h7777;
    st4 = 1'b1; st16 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0; st16 = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy4", int'(busy4), 0);
    chk("arst_done4", int'(done4), 0);
    chk("arst_busy16", int'(busy16), 0);
    diff = 0;
    for (int i = 0; i < 16; i++) begin rd(1, i % 4, i / 4, r); if (r != 2'b11) diff++; end
    chk("arst_walls4", diff, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
